// File: rtl/fetch_stage_pkg.sv
// Shared constants and next-PC source encodings for the fetch stage.
package fetch_stage_pkg;

   localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;
   localparam int          IM_WORDS   = 1024;

   typedef enum logic [1:0] {
      NPC_SEQ = 2'd0,
      NPC_BR  = 2'd1,
      NPC_J   = 2'd2,
      NPC_JR  = 2'd3
   } npc_sel_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: instruction memory port, decode control and IF/ID register.
interface fetch_stage_if;
   import fetch_stage_pkg::*;

   logic        stall;
   logic        clr;
   npc_sel_t    npc_sel;
   logic        br_taken;
   logic [31:0] rs_val;
   logic [31:0] im_addr;
   logic [31:0] im_data;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        adel_d;

   modport master (
      input  stall, clr, npc_sel, br_taken, rs_val, im_data,
      output im_addr, instr_d, pc_d, pc8_d, valid_d, adel_d
   );

   modport slave (
      output stall, clr, npc_sel, br_taken, rs_val, im_data,
      input  im_addr, instr_d, pc_d, pc8_d, valid_d, adel_d
   );

endinterface

// File: rtl/fetch_stage_npc.sv
// Combinational next-PC select; redirects use the decode-stage (IF/ID) fields.
module fetch_stage_npc
   import fetch_stage_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] pc_d,
   input  logic [31:0] instr_d,
   input  npc_sel_t    npc_sel,
   input  logic        br_taken,
   input  logic [31:0] rs_val,
   output logic [31:0] npc
);

   logic [31:0] br_off;

   assign br_off = {{14{instr_d[15]}}, instr_d[15:0], 2'b00};

   always_comb begin
      npc = pc + 32'd4;
      unique case (npc_sel)
         NPC_SEQ: npc = pc + 32'd4;
         NPC_BR:  if (br_taken) npc = pc_d + 32'd4 + br_off;
         NPC_J:   npc = {pc_d[31:28], instr_d[25:0], 2'b00};
         NPC_JR:  npc = rs_val;
         default: npc = pc + 32'd4;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register plus IF/ID pipeline register, zero-latency instruction memory.
module fetch_stage #(
   parameter logic [31:0] PC_DEFAULT = fetch_stage_pkg::PC_DEFAULT,
   parameter int          IM_WORDS   = fetch_stage_pkg::IM_WORDS
) (
   input  logic          clk,
   input  logic          reset,
   fetch_stage_if.master bus
);
   import fetch_stage_pkg::*;

   localparam logic [31:0] IM_BYTES = 32'(4 * IM_WORDS);

   logic [31:0] pc;
   logic [31:0] npc;
   logic        pc_bad;
   logic [31:0] instr_q;
   logic [31:0] pc_q;
   logic [31:0] pc8_q;
   logic        valid_q;
   logic        adel_q;

   // Offset compare wraps below PC_DEFAULT to a huge value, so one test covers both ends.
   assign pc_bad = (pc[1:0] != 2'b00) || ((pc - PC_DEFAULT) >= IM_BYTES);

   fetch_stage_npc u_npc (
      .pc       (pc),
      .pc_d     (pc_q),
      .instr_d  (instr_q),
      .npc_sel  (bus.npc_sel),
      .br_taken (bus.br_taken),
      .rs_val   (bus.rs_val),
      .npc      (npc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= PC_DEFAULT;
         instr_q <= '0;
         pc_q    <= PC_DEFAULT;
         pc8_q   <= PC_DEFAULT + 32'd8;
         valid_q <= 1'b0;
         adel_q  <= 1'b0;
      end else if (!bus.stall) begin
         pc    <= npc;
         pc_q  <= pc;
         pc8_q <= pc + 32'd8;
         if (bus.clr) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            adel_q  <= 1'b0;
         end else begin
            instr_q <= pc_bad ? 32'd0 : bus.im_data;
            valid_q <= 1'b1;
            adel_q  <= pc_bad;
         end
      end
   end

   assign bus.im_addr = pc;
   assign bus.instr_d = instr_q;
   assign bus.pc_d    = pc_q;
   assign bus.pc8_d   = pc8_q;
   assign bus.valid_d = valid_q;
   assign bus.adel_d  = adel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized run against a rule-level model.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   localparam logic [31:0] PCD = 32'h0000_3000;
   localparam int          NW  = 1024;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fetch_stage_if bus ();

   fetch_stage #(.PC_DEFAULT(PCD), .IM_WORDS(NW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [NW];
   logic [31:0] im_off;
   assign im_off      = bus.im_addr - PCD;
   assign bus.im_data = (bus.im_addr[1:0] == 2'b00 && im_off < 32'(4 * NW)) ? mem[im_off[11:2]] : 32'hBAD0_BAD0;

   // Reference model state: fetch PC and the contents of the IF/ID register.
   logic [31:0] m_pc, m_instr, m_pcd;
   logic        m_valid, m_adel;

   wire [129:0] act = {bus.im_addr, bus.instr_d, bus.pc_d, bus.pc8_d, bus.valid_d, bus.adel_d};

   function automatic logic [129:0] mexp();
      return {m_pc, m_instr, m_pcd, m_pcd + 32'd8, m_valid, m_adel};
   endfunction

   function automatic bit addr_bad(logic [31:0] a);
      longint la = longint'(a);
      return (a % 4 != 0) || la < longint'(PCD) || la > longint'(PCD) + 4 * NW - 4;
   endfunction

   task automatic mdl_reset();
      m_pc = PCD; m_instr = '0; m_pcd = PCD; m_valid = 1'b0; m_adel = 1'b0;
   endtask

   // One rising edge of the architectural behaviour, from the current bench inputs.
   task automatic mdl_edge();
      longint nxt;
      if (bus.stall) return;
      case (bus.npc_sel)
         NPC_BR:  nxt = bus.br_taken ? longint'(m_pcd) + 4 + 4 * longint'($signed(m_instr[15:0]))
                                     : longint'(m_pc) + 4;
         NPC_J:   nxt = longint'(m_pcd) / (1 << 28) * (1 << 28) + 4 * longint'(m_instr[25:0]);
         NPC_JR:  nxt = longint'(bus.rs_val);
         default: nxt = longint'(m_pc) + 4;
      endcase
      m_pcd = m_pc;
      if (bus.clr) begin
         m_instr = '0; m_valid = 1'b0; m_adel = 1'b0;
      end else begin
         m_valid = 1'b1;
         m_adel  = addr_bad(m_pc);
         m_instr = m_adel ? 32'd0 : mem[int'((longint'(m_pc) - longint'(PCD)) / 4)];
      end
      m_pc = nxt[31:0];
   endtask

   task automatic tick();
      mdl_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall = 1'b0; bus.clr = 1'b0; bus.npc_sel = NPC_SEQ; bus.br_taken = 1'b0; bus.rs_val = '0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      idle_inputs();
      mdl_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (act !== {PCD, 32'd0, PCD, PCD + 32'd8, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_state act=%h exp=%h", act, {PCD, 32'd0, PCD, PCD + 32'd8, 2'b00});
      end
   endtask

   task automatic test_sequential();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.pc_d !== PCD + 32'(4 * i) || bus.valid_d !== 1'b1 || bus.instr_d !== mem[i]) begin
            errors++; $display("FAIL seq_%0d pc_d=%h valid=%b instr=%h exp pc_d=%h instr=%h", i, bus.pc_d, bus.valid_d, bus.instr_d, PCD + 32'(4 * i), mem[i]);
         end
         checks++;
         if (act !== mexp()) begin
            errors++; $display("FAIL seq_model_%0d act=%h exp=%h", i, act, mexp());
         end
      end
   endtask

   task automatic test_branch();
      do_reset();
      tick(); tick();
      bus.npc_sel = NPC_BR; bus.br_taken = 1'b1;
      tick();
      bus.npc_sel = NPC_SEQ; bus.br_taken = 1'b0;
      checks++;
      if (bus.im_addr !== 32'h0000_3000 || bus.pc_d !== 32'h0000_3008) begin
         errors++; $display("FAIL branch_back im_addr=%h pc_d=%h exp 00003000 00003008", bus.im_addr, bus.pc_d);
      end
      bus.npc_sel = NPC_BR; bus.br_taken = 1'b0;
      tick();
      bus.npc_sel = NPC_SEQ;
      checks++;
      if (act !== mexp() || bus.im_addr !== 32'h0000_3004) begin
         errors++; $display("FAIL branch_not_taken act=%h exp=%h", act, mexp());
      end
   endtask

   task automatic test_jump();
      do_reset();
      repeat (5) tick();
      checks++;
      if (bus.pc_d !== 32'h0000_3010 || bus.pc8_d !== 32'h0000_3018) begin
         errors++; $display("FAIL jal_link pc_d=%h pc8_d=%h exp 00003010 00003018", bus.pc_d, bus.pc8_d);
      end
      bus.npc_sel = NPC_J;
      tick();
      bus.npc_sel = NPC_SEQ;
      checks++;
      if (bus.im_addr !== 32'h0000_3040 || act !== mexp()) begin
         errors++; $display("FAIL jump_target im_addr=%h exp=00003040 act=%h model=%h", bus.im_addr, act, mexp());
      end
   endtask

   task automatic test_stall();
      do_reset();
      tick(); tick();
      bus.stall = 1'b1; bus.npc_sel = NPC_JR; bus.rs_val = 32'h0000_3100; bus.clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (act !== {32'h0000_3008, mem[1], 32'h0000_3004, 32'h0000_300C, 1'b1, 1'b0}) begin
            errors++; $display("FAIL stall_hold_%0d act=%h model=%h", i, act, mexp());
         end
      end
      idle_inputs();
      tick();
      checks++;
      if (bus.pc_d !== 32'h0000_3008 || bus.instr_d !== mem[2] || act !== mexp()) begin
         errors++; $display("FAIL stall_resume pc_d=%h exp=00003008 act=%h model=%h", bus.pc_d, act, mexp());
      end
   endtask

   task automatic test_adel();
      do_reset();
      bus.npc_sel = NPC_JR; bus.rs_val = 32'h0000_3002;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.instr_d !== 32'd0 || bus.adel_d !== 1'b1 || bus.valid_d !== 1'b1 || bus.pc_d !== 32'h0000_3002) begin
         errors++; $display("FAIL adel_misaligned instr=%h adel=%b valid=%b pc_d=%h", bus.instr_d, bus.adel_d, bus.valid_d, bus.pc_d);
      end
      bus.npc_sel = NPC_JR; bus.rs_val = 32'h0000_4000;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.adel_d !== 1'b1 || bus.instr_d !== 32'd0 || bus.pc_d !== 32'h0000_4000) begin
         errors++; $display("FAIL adel_range adel=%b instr=%h pc_d=%h", bus.adel_d, bus.instr_d, bus.pc_d);
      end
      bus.npc_sel = NPC_JR; bus.rs_val = 32'h0000_3FFC;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.adel_d !== 1'b0 || bus.instr_d !== mem[NW - 1] || act !== mexp()) begin
         errors++; $display("FAIL adel_last_word adel=%b instr=%h exp=%h", bus.adel_d, bus.instr_d, mem[NW - 1]);
      end
   endtask

   task automatic test_clr_stall_reset();
      do_reset();
      tick(); tick();
      bus.clr = 1'b1; bus.stall = 1'b1;
      tick();
      checks++;
      if (bus.valid_d !== 1'b1 || bus.pc_d !== 32'h0000_3004 || bus.im_addr !== 32'h0000_3008) begin
         errors++; $display("FAIL clr_stall_hold valid=%b pc_d=%h im_addr=%h", bus.valid_d, bus.pc_d, bus.im_addr);
      end
      bus.stall = 1'b0;
      tick();
      bus.clr = 1'b0;
      checks++;
      if (act !== {32'h0000_300C, 32'd0, 32'h0000_3008, 32'h0000_3010, 1'b0, 1'b0}) begin
         errors++; $display("FAIL clr_bubble act=%h model=%h", act, mexp());
      end
      bus.stall = 1'b1; bus.npc_sel = NPC_JR; bus.rs_val = 32'h0000_3800;
      #2;
      reset = 1'b0;
      mdl_reset();
      #1;
      checks++;
      if (act !== {PCD, 32'd0, PCD, PCD + 32'd8, 1'b0, 1'b0}) begin
         errors++; $display("FAIL reset_async act=%h exp=%h", act, mexp());
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle_inputs();
      tick();
      checks++;
      if (bus.pc_d !== PCD || bus.valid_d !== 1'b1 || bus.instr_d !== mem[0] || bus.im_addr !== PCD + 32'd4) begin
         errors++; $display("FAIL reset_release pc_d=%h valid=%b im_addr=%h", bus.pc_d, bus.valid_d, bus.im_addr);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         bus.stall    = ($urandom_range(0, 4) == 0);
         bus.clr      = ($urandom_range(0, 6) == 0);
         bus.npc_sel  = npc_sel_t'($urandom_range(0, 3));
         bus.br_taken = 1'($urandom);
         bus.rs_val   = ($urandom_range(0, 9) < 8) ? PCD + 32'(4 * $urandom_range(0, NW - 1)) : $urandom;
         tick();
         checks++;
         if (act !== mexp()) begin
            errors++; $display("FAIL random_%0d act=%h exp=%h", i, act, mexp());
         end
      end
      idle_inputs();
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      for (int i = 0; i < NW; i++) mem[i] = $urandom;
      mem[1] = 32'h1000_FFFE;
      mem[4] = 32'h0C00_0C10;
      test_reset();
      test_sequential();
      test_branch();
      test_jump();
      test_stall();
      test_adel();
      test_clr_stall_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_DEFAULT, 32'h0000_3000, address of first fetched instruction after reset.
REQ-002 Parameter IM_WORDS, 1024, instruction memory depth in words; legal fetch range is PC_DEFAULT .. PC_DEFAULT+4*IM_WORDS-4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  hazard hold; freezes PC and IF/ID register.
REQ-006 clr  input  1  clears IF/ID register to a bubble.
REQ-007 npc_sel  input  2  next-PC source: 0 seq, 1 branch, 2 jump, 3 register.
REQ-008 br_taken  input  1  branch condition from decode, qualifies npc_sel=1.
REQ-009 rs_val  input  32  register target for npc_sel=3 (jr/jalr).
REQ-010 im_addr  output  32  current fetch PC, drives instruction memory address.
REQ-011 im_data  input  32  instruction word returned combinationally for im_addr.
REQ-012 instr_d  output  32  IF/ID instruction.
REQ-013 pc_d  output  32  IF/ID PC of instr_d.
REQ-014 pc8_d  output  32  pc_d+8, link value for jal/jalr.
REQ-015 valid_d  output  1  IF/ID holds a real instruction.
REQ-016 adel_d  output  1  instr_d came from a misaligned or out-of-range PC.

Function
REQ-017 PC register drives im_addr directly; im_data sampled into IF/ID in the same cycle (zero-latency IM).
REQ-018 Redirect computed from decode-stage fields (branch delay slot architecture; no squash of slot instruction):
 - npc_sel=0, or npc_sel=1 with br_taken=0: PC+4.
 - npc_sel=1, br_taken=1: pc_d+4+(sign_ext(instr_d[15:0])<<2).
 - npc_sel=2: {pc_d[31:28], instr_d[25:0], 2'b00}.
 - npc_sel=3: rs_val.
REQ-019 All next-PC arithmetic SHALL be 32-bit modulo 2^32; no overflow detection.
REQ-020 stall=1: PC and all IF/ID outputs hold; npc_sel, br_taken, clr ignored that cycle.
REQ-021 clr=1, stall=0: IF/ID loads instr_d=0, valid_d=0, adel_d=0, pc_d=PC; PC still advances per REQ-018.
REQ-022 Normal load: instr_d=im_data, pc_d=PC, pc8_d=PC+8, valid_d=1.
REQ-023 If PC[1:0]!=0 or PC outside legal range: instr_d=0 (nop), adel_d=1, valid_d=1; PC still advances per REQ-018.
REQ-024 Redirect to a bad target is not rejected; error surfaces via adel_d one cycle later.
REQ-025 Only the decode stage observes IF/ID; outputs SHALL be registered, no combinational path from inputs to IF/ID outputs.

Reset
REQ-026 reset low SHALL immediately set PC=PC_DEFAULT, instr_d=0, pc_d=PC_DEFAULT, pc8_d=PC_DEFAULT+8, valid_d=0, adel_d=0.
REQ-027 Reset asserted mid-stall or mid-redirect overrides everything; first edge after release loads IF/ID from PC_DEFAULT.

Structure
REQ-028 Shared package SHALL hold PC_DEFAULT, IM_WORDS, NPC_SEL encodings (SEQ, BR, J, JR).
REQ-029 Next-PC calculation SHALL be a combinational sub-module npc; fetch_stage holds PC and IF/ID registers.

Verification
REQ-030 Release reset, no stall -> instr_d from 0x3000, 0x3004, 0x3008 on successive edges; valid_d 0 then 1.
REQ-031 pc_d=0x3004, instr_d[15:0]=0xFFFE, npc_sel=1, br_taken=1 -> PC becomes 0x3000 (delay-slot 0x3008 still fetched first).
REQ-032 instr_d[25:0]=0x0000C10, pc_d=0x3010, npc_sel=2 -> PC=0x0000_3040; pc8_d of jal=0x3018.
REQ-033 stall high 3 cycles with npc_sel=3 -> PC and IF/ID unchanged; after release, fetch resumes from held PC.
REQ-034 npc_sel=3, rs_val=0x3002 -> next IF/ID instr_d=0, adel_d=1; rs_val=0x4000 (out of range) -> adel_d=1.
REQ-035 clr and stall both high -> hold wins; reset pulsed mid-run -> outputs to REQ-026 values asynchronously.
